// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: instruction word, register index, opcodes and the
// IF/ID latch state enum.
package cpu_types_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned OP_W   = 6;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;
   typedef logic [OP_W-1:0]   opcode_t;

   localparam opcode_t HALT = 6'h3F;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      HALTED = 1'b1
   } ifid_state_t;

   // Instruction plus its PC+4, as carried through the latch and skid buffer
   typedef struct packed {
      word_t instr;
      word_t npc;
   } fetch_t;

   function automatic opcode_t op_of(word_t w);
      return w[31:26];
   endfunction

endpackage

// File: rtl/ifid_latch_if.sv
// Fetch/hazard-side signals of the IF/ID pipeline latch.
interface ifid_latch_if;
   import cpu_types_pkg::*;

   logic     ihit;
   word_t    imemload;
   word_t    npc;
   logic     stall;
   logic     flush;
   logic     mem_wait;

   word_t    ifid_instr;
   word_t    ifid_npc;
   logic     ifid_valid;
   regbits_t ifid_rs;
   regbits_t ifid_rt;
   logic     pc_en;
   logic     halt;

   // Fetch stage and hazard unit drive the request side
   modport master (
      output ihit, imemload, npc, stall, flush, mem_wait,
      input  ifid_instr, ifid_npc, ifid_valid, ifid_rs, ifid_rt, pc_en, halt
   );

   modport slave (
      input  ihit, imemload, npc, stall, flush, mem_wait,
      output ifid_instr, ifid_npc, ifid_valid, ifid_rs, ifid_rt, pc_en, halt
   );

endinterface

// File: rtl/ifid_latch.sv
// IF/ID pipeline latch with a one-entry skid buffer that absorbs the
// instruction fetched during a freeze, plus HALT detection.
module ifid_latch
   import cpu_types_pkg::*;
(
   input  logic         CLK,
   input  logic         RST,
   ifid_latch_if.slave  bus
);

   ifid_state_t state_q, state_d;
   fetch_t      latch_q, latch_d;
   fetch_t      buf_q, buf_d;
   logic        valid_q, valid_d;
   logic        buf_valid_q, buf_valid_d;
   logic        halt_q, halt_d;
   logic        freeze;
   logic        flush_go;

   // Next-state: flush squashes everything, freeze holds (and may capture), else advance
   always_comb begin
      state_d     = state_q;
      latch_d     = latch_q;
      valid_d     = valid_q;
      buf_d       = buf_q;
      buf_valid_d = buf_valid_q;
      halt_d      = halt_q;
      freeze      = bus.stall | bus.mem_wait;
      flush_go    = bus.flush & ~bus.mem_wait;

      case (state_q)
         RUN: begin
            if (flush_go) begin
               latch_d     = '0;
               valid_d     = 1'b0;
               buf_valid_d = 1'b0;
            end else if (freeze) begin
               if (bus.ihit && !buf_valid_q) begin
                  buf_d       = '{instr: bus.imemload, npc: bus.npc};
                  buf_valid_d = 1'b1;
               end
            end else begin
               if (buf_valid_q) begin
                  latch_d     = buf_q;
                  valid_d     = 1'b1;
                  buf_valid_d = 1'b0;
               end else if (bus.ihit) begin
                  latch_d = '{instr: bus.imemload, npc: bus.npc};
                  valid_d = 1'b1;
               end else begin
                  latch_d = '0;
                  valid_d = 1'b0;
               end
               if (valid_d && (op_of(latch_d.instr) == HALT)) begin
                  state_d = HALTED;
                  halt_d  = 1'b1;
               end
            end
         end
         HALTED: begin
            // A flush means the HALT sat on the squashed path
            if (flush_go) begin
               latch_d     = '0;
               valid_d     = 1'b0;
               buf_valid_d = 1'b0;
               halt_d      = 1'b0;
               state_d     = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= RUN;
         latch_q     <= '0;
         valid_q     <= 1'b0;
         buf_q       <= '0;
         buf_valid_q <= 1'b0;
         halt_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         latch_q     <= latch_d;
         valid_q     <= valid_d;
         buf_q       <= buf_d;
         buf_valid_q <= buf_valid_d;
         halt_q      <= halt_d;
      end
   end

   // While reset is asserted the post-reset state is RUN with an empty buffer
   assign bus.pc_en      = bus.ihit & (RST | ((state_q == RUN) & ~buf_valid_q));
   assign bus.ifid_instr = latch_q.instr;
   assign bus.ifid_npc   = latch_q.npc;
   assign bus.ifid_valid = valid_q;
   assign bus.ifid_rs    = latch_q.instr[25:21];
   assign bus.ifid_rt    = latch_q.instr[20:16];
   assign bus.halt       = halt_q;

endmodule

// File: doc/ifid_latch.md
IFID_LATCH -- requirements
Module: ifid_latch

Interface
REQ-001 The block SHALL have CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have RST, input, 1, a synchronous, active-high reset.
REQ-003 The block SHALL have ihit, input, 1, the icache hit, meaning imemload is valid this cycle.
REQ-004 The block SHALL have imemload, input, word_t, the fetched instruction.
REQ-005 The block SHALL have npc, input, word_t, the PC+4 of the fetched instruction.
REQ-006 The block SHALL have stall, input, 1, the load-use stall from hazard_unit.
REQ-007 The block SHALL have flush, input, 1, the taken-branch/jump squash from hazard_unit.
REQ-008 The block SHALL have mem_wait, input, 1, the dmem busy signal; it freezes the whole pipe.
REQ-009 The block SHALL have ifid_instr, output, word_t, the latched instruction.
REQ-010 The block SHALL have ifid_npc, output, word_t, the latched PC+4.
REQ-011 The block SHALL have ifid_valid, output, 1, meaning the latch holds a real instruction.
REQ-012 The block SHALL have ifid_rs and ifid_rt, outputs, regbits_t, equal to ifid_instr[25:21] and [20:16], fed back to hazard_unit.
REQ-013 The block SHALL have pc_en, output, 1, the PC advance enable.
REQ-014 The block SHALL have halt, output, 1, a registered flag meaning a HALT instruction has reached IF/ID.

Function
REQ-015 The block SHALL define freeze = stall | mem_wait.
REQ-016 The block SHALL hold a one-entry skid buffer (buf_instr, buf_npc, buf_valid) that captures imemload/npc when ihit=1, freeze=1 and buf_valid=0.
REQ-017 In RUN with freeze=0 and flush=0, if buf_valid=1 the latch SHALL load from the buffer and clear buf_valid; else if ihit=1 it SHALL load imemload/npc with ifid_valid=1; else it SHALL insert a bubble (ifid_instr=0, ifid_valid=0).
REQ-018 With freeze=1 and flush=0, the latch contents SHALL hold unchanged.
REQ-019 flush=1 with mem_wait=0 SHALL clear the latch (instr=0, valid=0) and clear buf_valid in the same edge, overriding stall, ihit and buffer load.
REQ-020 flush SHALL be ignored while mem_wait=1; hazard_unit holds flush until mem_wait falls.
REQ-021 pc_en SHALL be combinational: pc_en = (state==RUN) & ihit & !buf_valid.
REQ-022 The FSM SHALL have states RUN and HALTED.
REQ-023 On an edge in RUN where the value being loaded into the latch has opcode [31:26]=6'h3F, next state SHALL be HALTED and halt SHALL be 1.
REQ-024 In HALTED, the latch and buffer SHALL hold, and pc_en SHALL be 0.
REQ-025 In HALTED, flush=1 with mem_wait=0 SHALL clear the latch, clear halt and return to RUN, because the HALT was on the squashed path.
REQ-026 The latency from ihit to ifid_valid SHALL be one edge when not frozen; no instruction is dropped or duplicated across any stall length.

Reset
REQ-027 RST=1 at an edge SHALL set state=RUN, ifid_instr=0, ifid_npc=0, ifid_valid=0, buf_valid=0 and halt=0.
REQ-028 Reset SHALL override freeze, flush and ihit, including mid-stall with a buffered instruction, which is discarded.
REQ-029 During reset, pc_en SHALL follow REQ-021 using the post-reset state.

Structure
REQ-030 word_t, regbits_t and the HALT opcode constant SHALL come from cpu_types_pkg; the FSM state enum SHALL be added to cpu_types_pkg.
REQ-031 There SHALL be no sub-modules; the skid buffer is inline.

Verification
REQ-032 Normal flow: ihit=1 with imemload=0x8C220004 then 0x00221820, no hazards -> ifid_instr follows one edge later, ifid_rs=1, ifid_rt=2, pc_en=1.
REQ-033 Load-use stall: latch=0x8C220004, stall=1 for 2 cycles while ihit=1 with 0x00421820 -> latch holds, buffer captures, pc_en=0 after capture; stall falls -> latch=0x00421820 next edge, no duplicate.
REQ-034 Flush with buffer: buf_valid=1, stall=1, flush=1 -> next edge ifid_valid=0, ifid_instr=0, buf_valid=0.
REQ-035 mem_wait: mem_wait=1 with flush=1 for 3 cycles -> latch unchanged; mem_wait falls -> cleared next edge.
REQ-036 Halt: load 0xFFFFFFFF -> halt=1, pc_en=0 thereafter; flush=1 -> halt=0, RUN, ifid_valid=0.
REQ-037 Reset mid-stall: RST=1 with buf_valid=1, stall=1 -> all outputs 0, buf_valid=0; after RST=0 and stall=0, the next ihit instruction is loaded directly.
